// File: rtl/bus_read_sequencer_if.sv
// Control/status and bus-facing signals of the register-bus reader, grouped for port hookup.
interface bus_read_sequencer_if #(
    parameter int unsigned NrOfBits = 16,
    parameter int unsigned NrOfRegs = 10,
    parameter int unsigned IdxBits  = 4
);
    logic                start;
    logic                mode;
    logic [IdxBits-1:0]  addr;
    logic [NrOfBits-1:0] bus_in;
    logic [NrOfRegs-1:0] cs;
    logic                busy;
    logic                done;
    logic                err;
    logic [NrOfBits-1:0] data_out;
    logic [IdxBits-1:0]  max_idx;
    logic [NrOfBits-1:0] max_val;

    // Requester side (also supplies the resolved bus value seen by the reader).
    modport master (
        output start, mode, addr, bus_in,
        input  cs, busy, done, err, data_out, max_idx, max_val
    );

    modport slave (
        input  start, mode, addr, bus_in,
        output cs, busy, done, err, data_out, max_idx, max_val
    );
endinterface

// File: rtl/bus_read_sequencer.sv
// Reader side of the shared tri-state register bus: owns every chip select, reads one register
// at a time with a break-before-make gap, and in scan mode reports the arg-max register.
module bus_read_sequencer #(
    parameter int unsigned NrOfBits     = 16,
    parameter int unsigned NrOfRegs     = 10,
    parameter int unsigned IdxBits      = 4,
    parameter int unsigned SettleCycles = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 tick_i,
    bus_read_sequencer_if.slave  ctrl_io
);

    localparam int unsigned CntBits = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntBits-1:0] SettleLast = CntBits'(SettleCycles - 1);
    localparam logic [IdxBits-1:0] IdxLast    = IdxBits'(NrOfRegs - 1);
    localparam logic [IdxBits:0]   NrOfRegsW  = (IdxBits + 1)'(NrOfRegs);

    typedef enum logic [1:0] {StIdle, StSelect, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [IdxBits-1:0]  idx_q, idx_d;
    logic [CntBits-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [NrOfBits-1:0] data_q, data_d;
    logic [IdxBits-1:0]  max_idx_q, max_idx_d;
    logic [NrOfBits-1:0] max_val_q, max_val_d;

    logic                addr_bad;
    logic [NrOfRegs-1:0] cs_sel;

    assign addr_bad = ({1'b0, ctrl_io.addr} >= NrOfRegsW);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            data_q    <= data_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        data_d    = data_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        case (state_q)
            StIdle: begin
                if (tick_i && ctrl_io.start) begin
                    mode_d = ctrl_io.mode;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    // An out-of-range single read never touches the bus.
                    if (!ctrl_io.mode && addr_bad) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = ctrl_io.mode ? '0 : ctrl_io.addr;
                        state_d = StSelect;
                    end
                end
            end
            StSelect: begin
                if (tick_i) begin
                    if (cnt_q == SettleLast) begin
                        data_d  = ctrl_io.bus_in;
                        cnt_d   = '0;
                        state_d = StGap;
                        // Strictly-greater update keeps the lowest index on ties.
                        if (mode_q && ((idx_q == '0) || (ctrl_io.bus_in > max_val_q))) begin
                            max_idx_d = idx_q;
                            max_val_d = ctrl_io.bus_in;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (tick_i) begin
                    if (!mode_q || (idx_q == IdxLast)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSelect;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs_sel = '1;
        if (state_q == StSelect) begin
            cs_sel[idx_q] = 1'b0;
        end
    end

    assign ctrl_io.cs       = cs_sel;
    assign ctrl_io.busy     = (state_q == StSelect) || (state_q == StGap);
    assign ctrl_io.done     = (state_q == StDone);
    assign ctrl_io.err      = err_q;
    assign ctrl_io.data_out = data_q;
    assign ctrl_io.max_idx  = max_idx_q;
    assign ctrl_io.max_val  = max_val_q;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed bench for bus_read_sequencer: two instances (settle 1 and settle 2) reading a
// modelled bank of ten tri-state registers.
module tb_bus_read_sequencer;

    logic Clock;
    logic Reset;
    logic tick1;
    logic tick2;

    logic [15:0] regs [10];

    int n_checks = 0;
    int n_pass   = 0;
    int overlap1 = 0;
    int overlap2 = 0;

    int          done_cyc1;
    logic [9:0]  cs_log1 [0:63];

    bus_read_sequencer_if #(.NrOfBits(16), .NrOfRegs(10), .IdxBits(4)) if1 ();
    bus_read_sequencer_if #(.NrOfBits(16), .NrOfRegs(10), .IdxBits(4)) if2 ();

    bus_read_sequencer #(
        .NrOfBits(16), .NrOfRegs(10), .IdxBits(4), .SettleCycles(1)
    ) dut1 (
        .Clock  (Clock),
        .Reset  (Reset),
        .tick_i (tick1),
        .ctrl_io(if1)
    );

    bus_read_sequencer #(
        .NrOfBits(16), .NrOfRegs(10), .IdxBits(4), .SettleCycles(2)
    ) dut2 (
        .Clock  (Clock),
        .Reset  (Reset),
        .tick_i (tick2),
        .ctrl_io(if2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register bank: whichever register has cs low drives the bus, otherwise it floats.
    always_comb begin
        if1.bus_in = 'z;
        for (int i = 0; i < 10; i++) if (!if1.cs[i]) if1.bus_in = regs[i];
    end

    always_comb begin
        if2.bus_in = 'z;
        for (int i = 0; i < 10; i++) if (!if2.cs[i]) if2.bus_in = regs[i];
    end

    always @(negedge Clock) begin
        if ($countones(~if1.cs) > 1) overlap1++;
        if ($countones(~if2.cs) > 1) overlap2++;
    end

    // Launches one request on dut1 and logs cs per cycle until done (cycle 1 follows the
    // start-sampling edge). done_cyc1 stays -1 if the budget expires.
    task automatic run_dut1(input logic m, input logic [3:0] a, input int budget);
        @(negedge Clock);
        if1.start = 1'b1;
        if1.mode  = m;
        if1.addr  = a;
        @(posedge Clock);
        done_cyc1 = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge Clock);
            if1.start  = 1'b0;
            cs_log1[k] = if1.cs;
            if (if1.done) begin
                done_cyc1 = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({if1.cs, if2.cs} !== 20'hFFFFF) $display("FAIL reset_cs got=%h exp=fffff",
                                                     {if1.cs, if2.cs});
        else n_pass++;
        n_checks++;
        if ({if1.busy, if1.done, if1.err} !== 3'b000)
            $display("FAIL reset_flags busy/done/err got=%b exp=000",
                     {if1.busy, if1.done, if1.err});
        else n_pass++;
        n_checks++;
        if ({if1.data_out, if1.max_idx, if1.max_val} !== 36'h0)
            $display("FAIL reset_data data/max_idx/max_val got=%h exp=0",
                     {if1.data_out, if1.max_idx, if1.max_val});
        else n_pass++;
    endtask

    task automatic test_single_read();
        regs[3] = 16'h1234;
        run_dut1(1'b0, 4'd3, 10);
        n_checks++;
        if (done_cyc1 !== 3) $display("FAIL single_done_cycle got=%0d exp=3", done_cyc1);
        else n_pass++;
        n_checks++;
        if (cs_log1[1] !== 10'h3F7) $display("FAIL single_cs_c1 got=%h exp=3f7", cs_log1[1]);
        else n_pass++;
        n_checks++;
        if (cs_log1[2] !== 10'h3FF) $display("FAIL single_cs_gap got=%h exp=3ff", cs_log1[2]);
        else n_pass++;
        n_checks++;
        if ({if1.data_out, if1.err, if1.busy} !== {16'h1234, 1'b0, 1'b0})
            $display("FAIL single_result data/err/busy got=%h/%b/%b exp=1234/0/0",
                     if1.data_out, if1.err, if1.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_select();
        int dones;
        @(negedge Clock);
        if1.start = 1'b1;
        if1.mode  = 1'b0;
        if1.addr  = 4'd3;
        @(posedge Clock);
        @(negedge Clock);
        if1.start = 1'b0;
        n_checks++;
        if (if1.cs !== 10'h3F7) $display("FAIL midrst_pre_cs got=%h exp=3f7", if1.cs);
        else n_pass++;
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if ({if1.cs, if1.busy, if1.done} !== {10'h3FF, 1'b0, 1'b0})
            $display("FAIL midrst_cs_busy_done got=%h/%b/%b exp=3ff/0/0",
                     if1.cs, if1.busy, if1.done);
        else n_pass++;
        n_checks++;
        if (if1.data_out !== 16'h0) $display("FAIL midrst_data got=%h exp=0000", if1.data_out);
        else n_pass++;
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            if (if1.done) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL midrst_no_done got=%0d exp=0", dones);
        else n_pass++;
    endtask

    task automatic test_scan();
        int bad;
        logic [9:0] exp_cs;
        regs = '{16'd5, 16'd9, 16'd2, 16'd9, 16'd0, 16'd1, 16'd7, 16'd3, 16'd8, 16'd4};
        run_dut1(1'b1, 4'd0, 40);
        n_checks++;
        if (done_cyc1 !== 21) $display("FAIL scan_done_cycle got=%0d exp=21", done_cyc1);
        else n_pass++;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            exp_cs = '1;
            if (k % 2 == 1) exp_cs[(k - 1) / 2] = 1'b0;
            if (cs_log1[k] !== exp_cs) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL scan_cs_sequence bad_cycles got=%0d exp=0", bad);
        else n_pass++;
        n_checks++;
        if ({if1.max_idx, if1.max_val} !== {4'd1, 16'd9})
            $display("FAIL scan_argmax idx/val got=%0d/%0d exp=1/9", if1.max_idx, if1.max_val);
        else n_pass++;
        n_checks++;
        if ({if1.data_out, if1.err} !== {16'd4, 1'b0})
            $display("FAIL scan_data_err got=%0d/%b exp=4/0", if1.data_out, if1.err);
        else n_pass++;
    endtask

    task automatic test_bad_addr();
        run_dut1(1'b0, 4'd12, 8);
        n_checks++;
        if (done_cyc1 !== 1) $display("FAIL badaddr_done_cycle got=%0d exp=1", done_cyc1);
        else n_pass++;
        n_checks++;
        if ({cs_log1[1], if1.err, if1.data_out} !== {10'h3FF, 1'b1, 16'd4})
            $display("FAIL badaddr_cs_err_data got=%h/%b/%0d exp=3ff/1/4",
                     cs_log1[1], if1.err, if1.data_out);
        else n_pass++;
        run_dut1(1'b0, 4'd6, 10);
        n_checks++;
        if ({if1.err, if1.data_out} !== {1'b0, 16'd7})
            $display("FAIL after_bad_read err/data got=%b/%0d exp=0/7", if1.err, if1.data_out);
        else n_pass++;
        n_checks++;
        if ({if1.max_idx, if1.max_val} !== {4'd1, 16'd9})
            $display("FAIL single_keeps_max got=%0d/%0d exp=1/9", if1.max_idx, if1.max_val);
        else n_pass++;
    endtask

    task automatic test_tick_scan();
        int sel_ticks [10];
        int phase;
        int bad_order;
        int bad_ticks;
        int cur;
        int done2;
        logic prev_low;
        for (int i = 0; i < 10; i++) sel_ticks[i] = 0;
        phase     = 0;
        bad_order = 0;
        prev_low  = 1'b0;
        done2     = -1;
        @(negedge Clock);
        if2.start = 1'b1;
        if2.mode  = 1'b1;
        if2.addr  = 4'd0;
        tick2     = 1'b1;
        @(posedge Clock);
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clock);
            if2.start = 1'b0;
            if (if2.done) begin
                done2 = k;
                break;
            end
            tick2 = ~tick2;
            cur = -1;
            for (int i = 0; i < 10; i++) if (!if2.cs[i]) cur = i;
            if (cur >= 0) begin
                if (!prev_low) begin
                    if (cur != phase) bad_order++;
                    phase++;
                end
                if (tick2) sel_ticks[cur]++;
            end
            prev_low = (cur >= 0);
        end
        tick2 = 1'b1;
        n_checks++;
        if (done2 < 0) $display("FAIL tick_scan_timeout got=no_done exp=done");
        else n_pass++;
        n_checks++;
        if ({phase, bad_order} !== {32'd10, 32'd0})
            $display("FAIL tick_scan_phases count/bad_order got=%0d/%0d exp=10/0",
                     phase, bad_order);
        else n_pass++;
        bad_ticks = 0;
        for (int i = 0; i < 10; i++) if (sel_ticks[i] != 2) bad_ticks++;
        n_checks++;
        if (bad_ticks !== 0) $display("FAIL tick_scan_settle bad_regs got=%0d exp=0", bad_ticks);
        else n_pass++;
        n_checks++;
        if ({if2.max_idx, if2.max_val, if2.data_out} !== {4'd1, 16'd9, 16'd4})
            $display("FAIL tick_scan_result idx/val/data got=%0d/%0d/%0d exp=1/9/4",
                     if2.max_idx, if2.max_val, if2.data_out);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int dones;
        logic busy_seen;
        dones     = 0;
        busy_seen = 1'b0;
        @(negedge Clock);
        if1.start = 1'b1;
        if1.mode  = 1'b0;
        if1.addr  = 4'd2;
        @(posedge Clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clock);
            if (if1.done) dones++;
            if (k == 1) busy_seen = if1.busy;
            if (k <= 2) begin
                if1.start = 1'b1;
                if1.addr  = 4'd5;
            end else begin
                if1.start = 1'b0;
            end
        end
        n_checks++;
        if (busy_seen !== 1'b1) $display("FAIL busy_after_start got=%b exp=1", busy_seen);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL busy_ignore_dones got=%0d exp=1", dones);
        else n_pass++;
        n_checks++;
        if (if1.data_out !== 16'd2) $display("FAIL busy_ignore_data got=%0d exp=2", if1.data_out);
        else n_pass++;
    endtask

    task automatic test_no_overlap();
        n_checks++;
        if ({overlap1, overlap2} !== 64'd0)
            $display("FAIL cs_overlap dut1/dut2 got=%0d/%0d exp=0/0", overlap1, overlap2);
        else n_pass++;
    endtask

    initial begin
        Reset     = 1'b1;
        tick1     = 1'b1;
        tick2     = 1'b1;
        if1.start = 1'b0;
        if1.mode  = 1'b0;
        if1.addr  = '0;
        if2.start = 1'b0;
        if2.mode  = 1'b0;
        if2.addr  = '0;
        regs = '{16'd5, 16'd9, 16'd2, 16'd9, 16'd0, 16'd1, 16'd7, 16'd3, 16'd8, 16'd4};
        #12;
        test_reset();
        @(negedge Clock);
        Reset = 1'b0;
        test_single_read();
        test_reset_mid_select();
        test_scan();
        test_bad_addr();
        test_tick_scan();
        test_busy_ignore();
        test_no_overlap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
